// File: rtl/audio_sample_feeder_if.sv
// Producer-to-feeder stereo sample stream: one {left,right} pair transfers per valid&ready beat.
interface audio_sample_feeder_if #(
  parameter int signalwidth = 16
);
  logic                   s_valid;
  logic                   s_ready;
  logic [signalwidth-1:0] s_left;
  logic [signalwidth-1:0] s_right;

  modport master (output s_valid, s_left, s_right, input s_ready);
  modport slave  (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/audio_sample_feeder.sv
// Stereo sample FIFO feeding the DAC at a clk-derived rate; samples leave registered on the tick edge.
// s_ready drops only while the FIFO is full; an empty FIFO at a tick holds q and flags underrun.
module audio_sample_feeder #(
  parameter int signalwidth = 16,
  parameter int depthbits   = 4,
  parameter int divwidth    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [divwidth-1:0]    divisor,
  input  logic                   signed_in,
  input  logic                   flush,
  audio_sample_feeder_if.slave   s,
  output logic [signalwidth-1:0] q_l,
  output logic [signalwidth-1:0] q_r,
  output logic                   tick,
  output logic [depthbits:0]     level,
  output logic                   underrun,
  input  logic                   underrun_clr
);
  localparam int depth = 1 << depthbits;
  localparam logic [depthbits:0]     full_level = (depthbits + 1)'(depth);
  localparam logic [signalwidth-1:0] midscale   = {1'b1, {(signalwidth - 1){1'b0}}};

  typedef logic [2*signalwidth-1:0] word_t;

  word_t                  mem [depth];
  logic [depthbits-1:0]   wptr;
  logic [depthbits-1:0]   rptr;
  logic [divwidth-1:0]    count;
  logic                   full;
  logic                   empty;
  logic                   tick_evt;
  logic                   push;
  logic                   pop;
  logic [signalwidth-1:0] sign_flip;
  word_t                  wr_word;
  word_t                  head;

  assign full      = (level == full_level);
  assign empty     = (level == '0);
  assign s.s_ready = !full;

  assign tick_evt  = enable && (count == '0);
  // flush wins over both queue operations in the same cycle
  assign push      = s.s_valid && !full && !flush;
  assign pop       = tick_evt && !empty && !flush;

  // Two's complement to offset binary is just an MSB flip
  assign sign_flip = signed_in ? midscale : '0;
  assign wr_word   = {s.s_left ^ sign_flip, s.s_right ^ sign_flip};
  assign head      = mem[rptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (!enable) begin
      count <= divisor;
      tick  <= 1'b0;
    end else if (count == '0) begin
      count <= divisor;
      tick  <= 1'b1;
    end else begin
      count <= count - 1'b1;
      tick  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_l      <= midscale;
      q_r      <= midscale;
      underrun <= 1'b0;
    end else begin
      if (pop) begin
        q_l <= head[2*signalwidth-1:signalwidth];
        q_r <= head[signalwidth-1:0];
      end
      // a fresh underrun beats a simultaneous clear
      if (tick_evt && empty && !flush) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_audio_sample_feeder.sv
// Randomized and directed bench for audio_sample_feeder against a queue-based sample-schedule model.
module tb_audio_sample_feeder;
  localparam int SW    = 16;
  localparam int DB    = 4;
  localparam int DEPTH = 1 << DB;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [15:0]   divisor;
  logic          signed_in;
  logic          flush;
  logic          underrun_clr;
  logic [SW-1:0] q_l;
  logic [SW-1:0] q_r;
  logic          tick;
  logic [DB:0]   level;
  logic          underrun;

  audio_sample_feeder_if #(.signalwidth(SW)) sif ();

  audio_sample_feeder #(.signalwidth(SW), .depthbits(DB), .divwidth(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .divisor      (divisor),
    .signed_in    (signed_in),
    .flush        (flush),
    .s            (sif.slave),
    .q_l          (q_l),
    .q_r          (q_r),
    .tick         (tick),
    .level        (level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: FIFO contents as a queue, tick schedule as the absolute edge number of the next tick
  logic [31:0]   mq[$];
  logic [SW-1:0] m_ql;
  logic [SW-1:0] m_qr;
  logic          m_tick;
  logic          m_und;
  longint        ecnt;
  longint        next_tick;
  int            n_vec;
  int            n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", nm, ecnt, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ql      = 16'h8000;
    m_qr      = 16'h8000;
    m_und     = 1'b0;
    m_tick    = 1'b0;
    next_tick = ecnt;
  endtask

  // Advance one clock edge: predict from inputs, clock the DUT, compare every output
  task automatic step();
    logic        tick_ev;
    logic        push;
    logic        emp;
    logic [31:0] w;
    logic [31:0] h;
    logic [15:0] flip;
    tick_ev = 1'b0;
    if (!enable) begin
      next_tick = ecnt + 1 + longint'(divisor);
    end else if (ecnt == next_tick) begin
      tick_ev   = 1'b1;
      next_tick = ecnt + 1 + longint'(divisor);
    end
    push = sif.s_valid && (mq.size() < DEPTH);
    emp  = (mq.size() == 0);
    flip = signed_in ? 16'h8000 : 16'h0000;
    w    = {sif.s_left ^ flip, sif.s_right ^ flip};
    if (tick_ev && emp && !flush) m_und = 1'b1;
    else if (underrun_clr)        m_und = 1'b0;
    if (flush) begin
      mq.delete();
    end else begin
      if (tick_ev && !emp) begin
        h    = mq.pop_front();
        m_ql = h[31:16];
        m_qr = h[15:0];
      end
      if (push) mq.push_back(w);
    end
    m_tick = tick_ev;
    @(posedge clk);
    #1;
    ecnt++;
    chk("tick", 32'(tick), 32'(m_tick));
    chk("q_l", 32'(q_l), 32'(m_ql));
    chk("q_r", 32'(q_r), 32'(m_qr));
    chk("level", 32'(level), 32'(mq.size()));
    chk("s_ready", 32'(sif.s_ready), 32'(mq.size() < DEPTH));
    chk("underrun", 32'(underrun), 32'(m_und));
  endtask

  task automatic run_to_tick(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < budget);
    if (tick !== 1'b1) chk("tick_timeout", 32'(tick), 32'd1);
  endtask

  task automatic push1(input logic [15:0] l, input logic [15:0] r);
    sif.s_valid = 1'b1;
    sif.s_left  = l;
    sif.s_right = r;
    step();
    sif.s_valid = 1'b0;
  endtask

  int n;

  initial begin
    n_vec = 0;
    n_err = 0;
    ecnt  = 0;
    reset_n = 1'b0;
    enable = 1'b0;
    divisor = 16'd9;
    signed_in = 1'b0;
    flush = 1'b0;
    underrun_clr = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_left = '0;
    sif.s_right = '0;
    model_reset();
    #12;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_q_l", 32'(q_l), 32'h8000);
    chk("rst_q_r", 32'(q_r), 32'h8000);
    chk("rst_ready", 32'(sif.s_ready), 32'd1);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    reset_n = 1'b1;

    // Unsigned sample, period of ten cycles
    push1(16'h1234, 16'h5678);
    enable = 1'b1;
    run_to_tick(40, n);
    chk("t2_first_tick_cycles", 32'(n), 32'd10);
    chk("t2_q_l", 32'(q_l), 32'h1234);
    chk("t2_q_r", 32'(q_r), 32'h5678);
    run_to_tick(40, n);
    chk("t2_period", 32'(n), 32'd10);

    // Signed sample conversion
    signed_in = 1'b1;
    push1(16'h0000, 16'hFFFF);
    signed_in = 1'b0;
    run_to_tick(40, n);
    chk("t3_q_l", 32'(q_l), 32'h8000);
    chk("t3_q_r", 32'(q_r), 32'h7FFF);

    // Fill to full with no ticks, then free one slot
    enable = 1'b0;
    divisor = 16'd2;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 17; i++) begin
      sif.s_valid = 1'b1;
      sif.s_left  = 16'(i * 16'h0101);
      sif.s_right = 16'(~(i * 16'h0101));
      step();
    end
    chk("t4_level_full", 32'(level), 32'd16);
    chk("t4_ready_full", 32'(sif.s_ready), 32'd0);
    enable = 1'b1;
    run_to_tick(20, n);
    chk("t4_level_after_tick", 32'(level), 32'd15);
    chk("t4_ready_after_tick", 32'(sif.s_ready), 32'd1);
    step();
    chk("t4_level_refill", 32'(level), 32'd16);
    sif.s_valid = 1'b0;

    // Underrun set and clear ordering
    enable = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    divisor = 16'd3;
    push1(16'h1111, 16'h2222);
    push1(16'h3333, 16'h4444);
    enable = 1'b1;
    run_to_tick(20, n);
    chk("t5_q_l_first", 32'(q_l), 32'h1111);
    run_to_tick(20, n);
    chk("t5_und_before", 32'(underrun), 32'd0);
    run_to_tick(20, n);
    chk("t5_q_l_held", 32'(q_l), 32'h3333);
    chk("t5_q_r_held", 32'(q_r), 32'h4444);
    chk("t5_und_set", 32'(underrun), 32'd1);
    for (int i = 0; i < 8 && next_tick != ecnt; i++) step();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("t5_clr_on_tick_tick", 32'(tick), 32'd1);
    chk("t5_clr_on_tick_und", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("t5_clr_alone", 32'(underrun), 32'd0);

    // Flush on a tick with divisor=0
    enable = 1'b0;
    divisor = 16'd0;
    for (int i = 0; i < 4; i++) push1(16'(16'hA000 + i), 16'(16'hB000 + i));
    chk("t6_level4", 32'(level), 32'd4);
    enable = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_tick", 32'(tick), 32'd1);
    chk("t6_level0", 32'(level), 32'd0);
    chk("t6_q_l_held", 32'(q_l), 32'h3333);
    chk("t6_und_clear", 32'(underrun), 32'd0);
    step();
    chk("t6_und_next", 32'(underrun), 32'd1);

    // Asynchronous reset mid-operation
    enable = 1'b0;
    divisor = 16'd20;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) push1(16'(i), 16'(i + 100));
    enable = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t1_level5", 32'(level), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_rst_level", 32'(level), 32'd0);
    chk("t1_rst_q_l", 32'(q_l), 32'h8000);
    chk("t1_rst_q_r", 32'(q_r), 32'h8000);
    chk("t1_rst_und", 32'(underrun), 32'd0);
    chk("t1_rst_ready", 32'(sif.s_ready), 32'd1);
    reset_n = 1'b1;
    model_reset();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) divisor = 16'($urandom_range(0, 7));
      enable       = ($urandom_range(0, 15) != 0);
      sif.s_valid  = ($urandom_range(0, 2) != 0);
      sif.s_left   = 16'($urandom);
      sif.s_right  = 16'($urandom);
      signed_in    = 1'($urandom);
      flush        = ($urandom_range(0, 63) == 0);
      underrun_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
